// File: rtl/rv32i_single_cycle_top.sv
// Single-cycle RV32I core with private instruction and data memories.
// One instruction retires on every rising clock edge; the memories are
// preloaded and inspected hierarchically through IM.mem and DM.mem.

// Word-organised memory: asynchronous read, byte-lane write on the clock edge.
// Indexes at or past memWords read as zero and swallow writes.
module rv32i_mem #(
  parameter int memWords = 100
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] widx,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [29:0] ridx,
  output logic [31:0] rdata
);
  localparam int AW = (memWords > 1) ? $clog2(memWords) : 1;

  logic [31:0] mem [0:memWords-1];
  logic        rd_in_range;
  logic        wr_in_range;

  assign rd_in_range = ridx < 30'(memWords);
  assign wr_in_range = widx < 30'(memWords);

  // Combinational read with out-of-range words forced to zero
  always_comb begin
    rdata = '0;
    if (rd_in_range) rdata = mem[ridx[AW-1:0]];
  end

  // Byte-lane write; lanes with be clear keep their old contents
  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

module rv32i_single_cycle_top #(
  parameter int memWords = 100
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_we;
  logic        wb_en;
  logic [31:0] wb_data;

  logic        unused_pc_lsb;

  // Instruction fetch ignores the byte offset of the PC
  assign unused_pc_lsb = ^pc[1:0];

  rv32i_mem #(.memWords(memWords)) IM (
    .clk   (clk),
    .we    (1'b0),
    .widx  (30'd0),
    .be    (4'd0),
    .wdata (32'd0),
    .ridx  (pc[31:2]),
    .rdata (instr)
  );

  rv32i_mem #(.memWords(memWords)) DM (
    .clk   (clk),
    .we    (dm_we & ~rst),
    .widx  (dm_addr[31:2]),
    .be    (dm_be),
    .wdata (dm_wdata),
    .ridx  (dm_addr[31:2]),
    .rdata (dm_rdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  // Loads and stores share one address adder; only the immediate differs
  assign dm_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  // Integer ALU shared by register and immediate forms; alt selects SUB/SRA
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'h0, (sa < sb)};
      3'b011:  r = {31'h0, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Picks the addressed lane(s) out of a memory word and extends them
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] shifted;
    shifted = word >> {ofs, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = ofs[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{byte_v[7]}}, byte_v};
      3'b001:  return {{16{half_v[15]}}, half_v};
      3'b100:  return {24'h0, byte_v};
      3'b101:  return {16'h0, half_v};
      default: return word;
    endcase
  endfunction

  // Byte-lane enables for a store of the given width at the given offset
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3)
      3'b000:  return 4'b0001 << ofs;
      3'b001:  return ofs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Next-PC, write-back and store control decoded from the current instruction
  always_comb begin
    next_pc  = pc + 32'd4;
    wb_en    = 1'b0;
    wb_data  = 32'h0;
    dm_we    = 1'b0;
    dm_be    = 4'h0;
    dm_wdata = 32'h0;
    case (opcode)
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc + 32'd4;
          next_pc = (rs1_val + imm_i) & ~32'h1;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000: if (rs1_val == rs2_val) next_pc = pc + imm_b;
          3'b001: if (rs1_val != rs2_val) next_pc = pc + imm_b;
          3'b100: if ($signed(rs1_val) <  $signed(rs2_val)) next_pc = pc + imm_b;
          3'b101: if ($signed(rs1_val) >= $signed(rs2_val)) next_pc = pc + imm_b;
          3'b110: if (rs1_val <  rs2_val) next_pc = pc + imm_b;
          3'b111: if (rs1_val >= rs2_val) next_pc = pc + imm_b;
          default: ;
        endcase
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          wb_en   = 1'b1;
          wb_data = load_ext(funct3, dm_addr[1:0], dm_rdata);
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
          dm_we    = 1'b1;
          dm_be    = store_be(funct3, dm_addr[1:0]);
          dm_wdata = (funct3 == 3'b000) ? {4{rs2_val[7:0]}} :
                     (funct3 == 3'b001) ? {2{rs2_val[15:0]}} : rs2_val;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'h00) begin
            wb_en   = 1'b1;
            wb_data = alu(funct3, 1'b0, rs1_val, imm_i);
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h00 || funct7 == 7'h20) begin
            wb_en   = 1'b1;
            wb_data = alu(funct3, funct7[5], rs1_val, imm_i);
          end
        end else begin
          wb_en   = 1'b1;
          wb_data = alu(funct3, 1'b0, rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          wb_en   = 1'b1;
          wb_data = alu(funct3, funct7[5], rs1_val, rs2_val);
        end
      end
      default: ;
    endcase
  end

  // Architectural state update: PC and register file retire together
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_rv32i_single_cycle_top.sv
// Bench for the single-cycle RV32I core: an instruction-level reference model
// runs in lock-step and every cycle PC, registers and data memory are compared;
// directed programs add hand-computed expectations.
module tb_rv32i_single_cycle_top;
  localparam int MW = 100;

  logic clk;
  logic rst;

  rv32i_single_cycle_top #(.memWords(MW)) top (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] prog [0:MW-1];
  int          plen;

  // Reference model state: byte-addressed data memory, word instruction memory
  logic [31:0] m_pc;
  logic [31:0] m_x   [0:31];
  logic [31:0] m_im  [0:MW-1];
  logic [7:0]  m_dmb [0:4*MW-1];

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  task automatic prog_clear();
    for (int i = 0; i < MW; i++) prog[i] = 32'h0;
    plen = 0;
  endtask
  task automatic p(input logic [31:0] ins);
    prog[plen] = ins;
    plen++;
  endtask

  // Same image into both DUT memories and into the model
  task automatic load_image();
    logic [31:0] v;
    for (int i = 0; i < MW; i++) begin
      v = prog[i];
      top.IM.mem[i] = v;
      top.DM.mem[i] = v;
      m_im[i] = v;
      for (int k = 0; k < 4; k++) m_dmb[4*i+k] = v[8*k +: 8];
    end
  endtask

  task automatic dm_set(input int idx, input logic [31:0] v);
    top.DM.mem[idx] = v;
    for (int k = 0; k < 4; k++) m_dmb[4*idx+k] = v[8*k +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hold reset across one edge with the program loaded, then release
  task automatic start(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1;
    load_image();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rdb(input logic [31:0] ad);
    if (ad[31:2] < MW) return m_dmb[ad];
    return 8'h00;
  endfunction
  function automatic logic [15:0] rdh(input logic [31:0] ad);
    logic [31:0] ha;
    ha = {ad[31:1], 1'b0};
    return {rdb(ha + 1), rdb(ha)};
  endfunction
  task automatic wrb(input logic [31:0] ad, input logic [7:0] d);
    if (ad[31:2] < MW) m_dmb[ad] = d;
  endtask

  // Executes one instruction per rising edge from the ISA rules
  always @(posedge clk) begin : model_step
    logic [31:0] w, a, b, ii, is, ib, ij, res, nxt, addr, wa, ha, opb;
    logic        wr, tk;
    logic [4:0]  sh;
    if (rst) begin
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    end else begin
      w   = (m_pc[31:2] < MW) ? m_im[m_pc[31:2]] : 32'h0;
      a   = m_x[w[19:15]];
      b   = m_x[w[24:20]];
      ii  = 32'($signed(w[31:20]));
      is  = 32'($signed({w[31:25], w[11:7]}));
      ib  = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      ij  = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      nxt = m_pc + 4;
      wr  = 1'b0;
      res = 32'h0;
      case (w[6:0])
        7'h37: begin res = {w[31:12], 12'h0}; wr = 1'b1; end
        7'h17: begin res = m_pc + {w[31:12], 12'h0}; wr = 1'b1; end
        7'h6f: begin res = m_pc + 4; wr = 1'b1; nxt = m_pc + ij; end
        7'h67: if (w[14:12] == 3'd0) begin res = m_pc + 4; wr = 1'b1; nxt = (a + ii) & ~32'h1; end
        7'h63: begin
          case (w[14:12])
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
          endcase
          if (tk) nxt = m_pc + ib;
        end
        7'h03: begin
          addr = a + ii;
          wa   = {addr[31:2], 2'b00};
          wr   = 1'b1;
          case (w[14:12])
            3'd0: res = 32'($signed(rdb(addr)));
            3'd1: res = 32'($signed(rdh(addr)));
            3'd2: res = {rdb(wa + 3), rdb(wa + 2), rdb(wa + 1), rdb(wa)};
            3'd4: res = {24'h0, rdb(addr)};
            3'd5: res = {16'h0, rdh(addr)};
            default: wr = 1'b0;
          endcase
        end
        7'h23: begin
          addr = a + is;
          wa   = {addr[31:2], 2'b00};
          ha   = {addr[31:1], 1'b0};
          case (w[14:12])
            3'd0: wrb(addr, b[7:0]);
            3'd1: begin wrb(ha, b[7:0]); wrb(ha + 1, b[15:8]); end
            3'd2: for (int k = 0; k < 4; k++) wrb(wa + k, b[8*k +: 8]);
            default: ;
          endcase
        end
        7'h13, 7'h33: begin
          opb = (w[6:0] == 7'h33) ? b : ii;
          sh  = opb[4:0];
          wr  = 1'b1;
          case (w[14:12])
            3'd0: res = (w[6:0] == 7'h33 && w[30]) ? a - opb : a + opb;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            3'd3: res = (a < opb) ? 32'd1 : 32'd0;
            3'd4: res = a ^ opb;
            3'd5: res = w[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: res = a | opb;
            default: res = a & opb;
          endcase
        end
        default: ;
      endcase
      if (wr && w[11:7] != 5'd0) m_x[w[11:7]] = res;
      m_pc = nxt;
    end
  end

  // Per-cycle comparison of architectural state against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      logic [31:0] mw;
      n_tests++;
      if (top.pc !== m_pc) begin
        n_fail++;
        $display("FAIL model pc: got %h, expected %h", top.pc, m_pc);
      end
      bad = -1;
      for (int i = 0; i < 32; i++) if (bad < 0 && top.regs[i] !== m_x[i]) bad = i;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL model x%0d: got %h, expected %h", bad, top.regs[bad], m_x[bad]);
      end
      bad = -1;
      for (int i = 0; i < MW; i++) begin
        mw = {m_dmb[4*i+3], m_dmb[4*i+2], m_dmb[4*i+1], m_dmb[4*i]};
        if (bad < 0 && top.DM.mem[i] !== mw) bad = i;
      end
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL model dm[%0d]: got %h, expected %h", bad, top.DM.mem[bad],
                 {m_dmb[4*bad+3], m_dmb[4*bad+2], m_dmb[4*bad+1], m_dmb[4*bad]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;

    // Load/store lanes, with a reset landing on the store
    prog_clear();
    p(addi(1, 0, 80));
    p(addi(2, 0, 32'hAB));
    p(enc_s(1, 2, 1, 0));                 // sb x2,1(x1)
    p(enc_i(0, 1, 2, 3, 7'h03));          // lw x3,0(x1)
    p(enc_i(1, 1, 0, 4, 7'h03));          // lb x4,1(x1)
    p(enc_i(1, 1, 4, 5, 7'h03));          // lbu x5,1(x1)
    p(enc_i(2, 1, 1, 6, 7'h03));          // lh x6,2(x1)
    start(3);
    dm_set(20, 32'h11223344);
    run(2);
    rst = 1'b1;
    run(1);
    check("reset pc", top.pc, 32'h0);
    check("reset x1", top.regs[1], 32'h0);
    check("reset x2", top.regs[2], 32'h0);
    check("reset dm20 kept", top.DM.mem[20], 32'h11223344);
    rst = 1'b0;
    run(7);
    check("lanes x3", top.regs[3], 32'h1122AB44);
    check("lanes x4", top.regs[4], 32'hFFFFFFAB);
    check("lanes x5", top.regs[5], 32'h000000AB);
    check("lanes x6", top.regs[6], 32'h00001122);
    check("lanes pc", top.pc, 32'h1C);

    // Arithmetic
    prog_clear();
    p(addi(1, 0, 5));
    p(addi(2, 0, -3));
    p(enc_r(0, 0, 3, 1, 2));              // add
    p(enc_r(32, 0, 4, 1, 2));             // sub
    p(enc_r(0, 2, 5, 2, 1));              // slt
    p(enc_r(0, 3, 6, 2, 1));              // sltu
    p(addi(0, 0, 7));
    start(1);
    run(7);
    check("arith x3", top.regs[3], 32'd2);
    check("arith x4", top.regs[4], 32'd8);
    check("arith x5", top.regs[5], 32'd1);
    check("arith x6", top.regs[6], 32'd0);
    check("arith x0", top.regs[0], 32'd0);
    check("arith pc", top.pc, 32'h1C);

    // Branches and jumps
    prog_clear();
    p(addi(1, 0, 1));
    p(enc_b(8, 0, 1, 0));                 // beq x1,x0,8
    p(enc_b(8, 0, 1, 1));                 // bne x1,x0,8
    p(addi(7, 0, 99));
    p(enc_j(12, 2));                      // jal x2,12
    p(addi(8, 0, 1));
    p(addi(9, 0, 1));
    p(enc_i(3, 2, 0, 3, 7'h67));          // jalr x3,x2,3
    start(2);
    run(5);
    check("br pc", top.pc, 32'h16);
    check("br x2", top.regs[2], 32'h14);
    check("br x3", top.regs[3], 32'h20);
    check("br x7", top.regs[7], 32'h0);
    run(3);
    check("br x8", top.regs[8], 32'h1);
    check("br x9", top.regs[9], 32'h1);
    check("br x3 again", top.regs[3], 32'h22);
    check("br pc again", top.pc, 32'h16);

    // Shifts and upper immediates
    prog_clear();
    p(enc_u(32'h80000, 1, 7'h37));        // lui
    p(enc_i(32'h404, 1, 5, 2, 7'h13));    // srai x2,x1,4
    p(enc_i(32'h004, 1, 5, 3, 7'h13));    // srli x3,x1,4
    p(enc_u(32'h1, 4, 7'h17));            // auipc x4,1
    start(1);
    run(4);
    check("shift x2", top.regs[2], 32'hF8000000);
    check("shift x3", top.regs[3], 32'h08000000);
    check("shift x4", top.regs[4], 32'h0000100C);
    check("shift pc", top.pc, 32'h10);

    // Out-of-range data access and fetch
    prog_clear();
    p(addi(1, 0, 400));
    p(addi(2, 0, -1));
    p(addi(3, 0, 5));
    p(enc_s(0, 2, 1, 2));                 // sw x2,0(x1)
    p(enc_i(0, 1, 2, 3, 7'h03));          // lw x3,0(x1)
    p(enc_i(0, 1, 0, 0, 7'h67));          // jalr x0,x1,0
    start(1);
    run(10);
    check("oor x3", top.regs[3], 32'h0);
    check("oor pc", top.pc, 32'h1A0);
    check("oor dm99", top.DM.mem[99], 32'h0);

    // Remaining ALU, halfword and branch forms
    prog_clear();
    p(addi(1, 0, -16));
    p(addi(2, 0, 3));
    p(enc_r(0, 1, 3, 1, 2));              // sll
    p(enc_r(0, 5, 4, 1, 2));              // srl
    p(enc_r(32, 5, 5, 1, 2));             // sra
    p(enc_r(0, 4, 6, 1, 2));              // xor
    p(enc_r(0, 6, 7, 1, 2));              // or
    p(enc_r(0, 7, 8, 1, 2));              // and
    p(enc_i(-15, 1, 2, 9, 7'h13));        // slti
    p(enc_i(5, 1, 3, 10, 7'h13));         // sltiu
    p(enc_i(-1, 2, 4, 11, 7'h13));        // xori
    p(enc_i(32'h70, 2, 6, 12, 7'h13));    // ori
    p(enc_i(32'h7F, 1, 7, 13, 7'h13));    // andi
    p(enc_i(30, 2, 1, 14, 7'h13));        // slli
    p(enc_s(2, 1, 0, 1));                 // sh x1,2(x0)
    p(enc_i(2, 0, 5, 15, 7'h03));         // lhu
    p(enc_i(2, 0, 1, 16, 7'h03));         // lh
    p(enc_b(8, 2, 1, 4));                 // blt taken
    p(addi(17, 0, 1));
    p(enc_b(8, 2, 1, 6));                 // bltu not taken
    p(enc_b(8, 2, 1, 5));                 // bge not taken
    p(enc_b(8, 2, 1, 7));                 // bgeu taken
    p(addi(18, 0, 1));
    p(addi(19, 0, 7));
    p(32'h00000073);                      // ecall
    p(enc_r(32, 0, 20, 2, 1));            // sub x20,x2,x1
    start(1);
    run(26);
    check("mix x5", top.regs[5], 32'hFFFFFFFE);
    check("mix x14", top.regs[14], 32'hC0000000);
    check("mix x15", top.regs[15], 32'h0000FFF0);
    check("mix x16", top.regs[16], 32'hFFFFFFF0);
    check("mix x17", top.regs[17], 32'h0);
    check("mix x18", top.regs[18], 32'h0);
    check("mix x19", top.regs[19], 32'h7);
    check("mix x20", top.regs[20], 32'd19);
    check("mix dm0 hi", {16'h0, top.DM.mem[0][31:16]}, 32'h0000FFF0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_single_cycle_top.md
# rv32i_single_cycle_top

Single-cycle RV32I processor core with its own instruction memory and data memory, instantiated as module `top`. Each clock edge retires exactly one instruction. The block is the top of the simulation hierarchy. Benches preload both memories through hierarchical paths and observe state; there are no functional I/O ports beyond clock and reset.

## Interface
- memWords, default 100: depth of each memory, in 32-bit words.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- Instance `IM`: instruction memory, storage array `mem[0:memWords-1]`, 32-bit words.
- Instance `DM`: data memory, storage array `mem[0:memWords-1]`, 32-bit words.
- Both arrays are loadable by `$readmemh` through `top.IM.mem` and `top.DM.mem`.
- The same image is loaded into both memories.

## Operation
- PC is 32 bits.
- Instruction fetch: `IM.mem[PC[31:2]]`. A word index ≥ memWords fetches 0x00000000, which executes as a NOP.
- Register file: x0..x31, 32 bits each.
  - x0 reads 0 and ignores writes.
  - Two combinational read ports, one write port.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- FENCE, ECALL, EBREAK and any undecodable opcode execute as a NOP: PC+4, no register or memory write.
- Immediates: standard I/S/B/U/J formats, sign-extended to 32 bits.
- Arithmetic:
  - Modulo 2^32; no overflow trap.
  - Shift amount is rs2[4:0] or shamt[4:0].
  - SRA/SRAI replicate bit 31.
- Next PC:
  - Default PC+4.
  - Taken branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: (rs1+immI) & ~1.
  - JAL/JALR write PC+4 to rd, using the rs1 value read before the write.
  - PC wraps at 2^32.
- Data memory addressing: word index = addr[31:2].
  - LW/SW ignore addr[1:0].
  - LH/LHU/SH select a halfword by addr[1].
  - LB/LBU/SB select a byte by addr[1:0].
  - Little-endian byte lanes: lane 0 = bits 7:0.
- Loads sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Stores write only the addressed byte lanes; other bytes of the word are preserved.
- A data access with word index ≥ memWords reads 0; a store to it is ignored.
- No halt state: execution continues until simulation ends.

## Timing
- Combinational within a cycle: fetch, decode, register read, ALU, DM read, write-back mux.
- Rising clk edge: PC update, register write, DM write, all on the same edge.
- Reads in the same cycle see pre-edge values.
- Latency: an instruction's result is visible in its destination one edge after the instruction is presented.
- Reset: if rst=1 at a rising edge, then
  - PC ← 0x00000000,
  - x1..x31 ← 0,
  - no DM or IM write occurs.
  - Memory contents are never cleared by reset.
- Reset asserted mid-program:
  - The instruction in flight that cycle is discarded.
  - The first edge with rst=0 executes the instruction at address 0.
- Reset holds for any number of cycles.
- Output-free block: the observable state after reset is PC=0 and all GPRs = 0.

## Test plan
- Reset: run 5 cycles, assert rst for one edge → PC=0, x1..x31=0; DM contents unchanged.
- Arithmetic: program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; slt x5,x2,x1; sltu x6,x2,x1; addi x0,x0,7` → after 7 edges: x3=2, x4=8, x5=1, x6=0, x0=0, PC=0x1C.
- Load/store lanes:
  - Preset DM word 20 = 0x11223344.
  - Run `addi x1,x0,80; addi x2,x0,0xAB; sb x2,1(x1); lw x3,0(x1); lb x4,1(x1); lbu x5,1(x1); lh x6,2(x1)`.
  - Expect x3=0x1122AB44, x4=0xFFFFFFAB, x5=0x000000AB, x6=0x00001122.
- Branch/jump:
  - `addi x1,x0,1; beq x1,x0,8; bne x1,x0,8` → the bne is taken (PC+8).
  - `jal x2,12` from PC=0x10 → x2=0x14, PC=0x1C.
  - `jalr x3,x2,3` with x2=0x14 → PC=0x16, x3=PC+4.
- Shifts/upper:
  - `lui x1,0x80000; srai x2,x1,4; srli x3,x1,4; auipc x4,1` at PC=0x0C → x2=0xF8000000, x3=0x08000000, x4=0x0000100C.
- Out-of-range: `sw` to word index memWords, then `lw` from it → store is ignored and x-reg reads 0; a fetch past memWords proceeds as NOPs with PC+4.
